// File: rtl/pet_bus_arbiter.sv
// pet_bus_arbiter: time-slot arbiter sharing one synchronous RAM between
// the 6502 core (fixed PRE/CPU window at the end of each period) and video.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_addr/cpu_data_out/cpu_we/cpu_pause in; cpu_rdy/cpu_data_in out
//   vid_req/vid_addr in; vid_grant/vid_rvalid/vid_rdata out
//   ram_addr/ram_we/ram_wdata out; ram_rdata in (1-cycle registered read)
module pet_bus_arbiter #(
    parameter int CPU_DIV = 50,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_we,
    input  logic        cpu_pause,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_data_in,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_grant,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam logic [CNT_W-1:0] SLOT_PRE = CNT_W'(CPU_DIV - 2);
    localparam logic [CNT_W-1:0] SLOT_CPU = CNT_W'(CPU_DIV - 1);

    typedef enum logic [1:0] {
        PH_VID,
        PH_PRE,
        PH_CPU
    } phase_e;

    phase_e           phase;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic             pause_l_q, pause_l_d;
    logic             vid_rvalid_q, vid_rvalid_d;
    logic [7:0]       vid_hold_q, vid_hold_d;
    logic [7:0]       cpu_hold_q, cpu_hold_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q       <= '0;
            pause_l_q    <= 1'b0;
            vid_rvalid_q <= 1'b0;
            vid_hold_q   <= 8'h00;
            cpu_hold_q   <= 8'h00;
        end else begin
            slot_q       <= slot_d;
            pause_l_q    <= pause_l_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_hold_q   <= vid_hold_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    always_comb begin
        phase = PH_VID;
        unique case (1'b1)
            (slot_q == SLOT_CPU): phase = PH_CPU;
            (slot_q == SLOT_PRE): phase = PH_PRE;
            default:              phase = PH_VID;
        endcase
    end

    // Bus outputs are gated by reset so the RAM port and grant go quiet
    // the instant reset asserts, even though vid_req/cpu_* are still live.
    always_comb begin
        cpu_rdy   = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        ram_addr  = 16'h0000;
        vid_grant = 1'b0;
        if (reset) begin
            unique case (phase)
                PH_PRE: begin
                    ram_addr = cpu_addr;
                end
                PH_CPU: begin
                    ram_addr  = cpu_addr;
                    cpu_rdy   = ~pause_l_q;
                    ram_we    = cpu_we & ~pause_l_q;
                    ram_wdata = cpu_data_out;
                end
                default: begin
                    if (vid_req) begin
                        vid_grant = 1'b1;
                        ram_addr  = vid_addr;
                    end
                end
            endcase
        end
    end

    // The CPU cycle sees the PRE read directly; the hold keeps it afterwards.
    always_comb begin
        cpu_data_in = (phase == PH_CPU) ? ram_rdata : cpu_hold_q;
        vid_rdata   = vid_rvalid_q ? ram_rdata : vid_hold_q;
        vid_rvalid  = vid_rvalid_q;
    end

    always_comb begin
        slot_d       = slot_q + 1'b1;
        pause_l_d    = pause_l_q;
        cpu_hold_d   = cpu_hold_q;
        vid_hold_d   = vid_hold_q;
        vid_rvalid_d = vid_grant;
        if (phase == PH_CPU) begin
            slot_d     = '0;
            cpu_hold_d = ram_rdata;
        end
        if (phase == PH_PRE) begin
            pause_l_d = cpu_pause;
        end
        if (vid_rvalid_q) begin
            vid_hold_d = ram_rdata;
        end
    end

endmodule

// File: tb/tb_pet_bus_arbiter.sv
// Bench for pet_bus_arbiter: two instances (CPU_DIV=4 and 6) share stimulus,
// each with its own RAM and a slot-position model checked every cycle.
module tb_pet_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_we;
  logic        cpu_pause;
  logic        vid_req;
  logic [15:0] vid_addr;

  logic        rdy4, gnt4, rv4, we4;
  logic [7:0]  din4, vrd4, wd4;
  logic [7:0]  rd4 = 8'h00;
  logic [15:0] ra4;
  logic        rdy6, gnt6, rv6, we6;
  logic [7:0]  din6, vrd6, wd6;
  logic [7:0]  rd6 = 8'h00;
  logic [15:0] ra6;

  pet_bus_arbiter #(.CPU_DIV(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .cpu_pause(cpu_pause),
    .cpu_rdy(rdy4), .cpu_data_in(din4),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_grant(gnt4), .vid_rvalid(rv4), .vid_rdata(vrd4),
    .ram_addr(ra4), .ram_we(we4), .ram_wdata(wd4),
    .ram_rdata(rd4)
  );

  pet_bus_arbiter #(.CPU_DIV(6), .CNT_W(3)) u_dut6 (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .cpu_pause(cpu_pause),
    .cpu_rdy(rdy6), .cpu_data_in(din6),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_grant(gnt6), .vid_rvalid(rv6), .vid_rdata(vrd6),
    .ram_addr(ra6), .ram_we(we6), .ram_wdata(wd6),
    .ram_rdata(rd6)
  );

  logic [7:0] mem4 [65536];
  logic [7:0] mem6 [65536];

  always @(posedge clk) begin
    rd4 <= mem4[ra4];
    if (we4) mem4[ra4] <= wd4;
    rd6 <= mem6[ra6];
    if (we6) mem6[ra6] <= wd6;
  end

  always @(negedge clk) begin
    assert (!(we4 && $isunknown(ra4)))
      else $error("FAIL x_addr_we4: ram_we with unknown address");
    assert (!(we6 && $isunknown(ra6)))
      else $error("FAIL x_addr_we6: ram_we with unknown address");
  end

  typedef struct packed {
    logic        rdy;
    logic        grant;
    logic        rvalid;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  vrd;
    logic [7:0]  wd;
  } obs_t;

  // Model: position in period, pause seen at PRE, shadow memory.
  int         m_pos [2];
  bit         m_pause [2];
  bit         m_rv [2];
  logic [7:0] m_pre [2];
  logic [7:0] m_chold [2];
  logic [7:0] m_vdat [2];
  logic [7:0] m_vhold [2];
  logic [7:0] sh [2][65536];

  int         n_pass = 0;
  int         n_chk = 0;
  int         rdy_cnt [2];
  int         we_cnt [2];
  int         gnt_cnt [2];
  int         rv_cnt [2];
  logic [7:0] rdy_din [2];
  bit         last_rdy [2];

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic obs_t expect_of(int k);
    obs_t e;
    int   d;
    bit   vid;
    e = '0;
    d = div_of(k);
    if (!reset) return e;
    vid      = m_pos[k] < d - 2;
    e.rdy    = (m_pos[k] == d - 1) && !m_pause[k];
    e.we     = e.rdy && cpu_we;
    e.grant  = vid && vid_req;
    e.addr   = !vid ? cpu_addr : (vid_req ? vid_addr : 16'h0000);
    e.wd     = cpu_data_out;
    e.rvalid = m_rv[k];
    e.din    = (m_pos[k] == d - 1) ? m_pre[k] : m_chold[k];
    e.vrd    = m_rv[k] ? m_vdat[k] : m_vhold[k];
    return e;
  endfunction

  function automatic obs_t actual(int k);
    obs_t a;
    if (k == 0) a = {rdy4, gnt4, rv4, we4, ra4, din4, vrd4, wd4};
    else        a = {rdy6, gnt6, rv6, we6, ra6, din6, vrd6, wd6};
    return a;
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic compare_cycle();
    obs_t e, a;
    for (int k = 0; k < 2; k++) begin
      e = expect_of(k);
      a = actual(k);
      chk($sformatf("rdy_d%0d", div_of(k)), 16'(a.rdy), 16'(e.rdy));
      chk($sformatf("grant_d%0d", div_of(k)), 16'(a.grant), 16'(e.grant));
      chk($sformatf("rvalid_d%0d", div_of(k)), 16'(a.rvalid), 16'(e.rvalid));
      chk($sformatf("ram_we_d%0d", div_of(k)), 16'(a.we), 16'(e.we));
      chk($sformatf("ram_addr_d%0d", div_of(k)), a.addr, e.addr);
      chk($sformatf("cpu_din_d%0d", div_of(k)), 16'(a.din), 16'(e.din));
      chk($sformatf("vid_rdata_d%0d", div_of(k)), 16'(a.vrd), 16'(e.vrd));
      if (e.we || !reset)
        chk($sformatf("ram_wdata_d%0d", div_of(k)), 16'(a.wd),
            16'(e.wd & {8{reset}}));
      last_rdy[k] = a.rdy;
      if (a.rdy) begin
        rdy_cnt[k]++;
        rdy_din[k] = a.din;
      end
      if (a.we) we_cnt[k]++;
      if (a.grant) gnt_cnt[k]++;
      if (a.rvalid) rv_cnt[k]++;
    end
  endtask

  task automatic model_update();
    obs_t e;
    int   d;
    for (int k = 0; k < 2; k++) begin
      d = div_of(k);
      e = expect_of(k);
      if (!reset) begin
        m_pos[k]   = 0;
        m_pause[k] = 0;
        m_rv[k]    = 0;
        m_pre[k]   = 8'h00;
        m_chold[k] = 8'h00;
        m_vdat[k]  = 8'h00;
        m_vhold[k] = 8'h00;
      end else begin
        if (m_pos[k] == d - 2) begin
          m_pre[k]   = sh[k][cpu_addr];
          m_pause[k] = cpu_pause;
        end
        if (m_pos[k] == d - 1) begin
          m_chold[k] = m_pre[k];
          if (e.we) sh[k][cpu_addr] = cpu_data_out;
        end
        if (m_rv[k]) m_vhold[k] = m_vdat[k];
        m_rv[k] = e.grant;
        if (e.grant) m_vdat[k] = sh[k][vid_addr];
        m_pos[k] = (m_pos[k] + 1) % d;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      rdy_cnt[k] = 0;
      we_cnt[k]  = 0;
      gnt_cnt[k] = 0;
      rv_cnt[k]  = 0;
      rdy_din[k] = 8'h00;
    end
  endtask

  int  first [2];
  bit  found;
  int  n;

  initial begin
    reset        = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_we       = 1'b0;
    cpu_pause    = 1'b0;
    vid_req      = 1'b0;
    vid_addr     = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem4[i]  = a[7:0] ^ a[15:8];
      mem6[i]  = a[7:0] ^ a[15:8];
      sh[0][i] = a[7:0] ^ a[15:8];
      sh[1][i] = a[7:0] ^ a[15:8];
    end
    mem4[16'h1234]  = 8'hA5;
    mem6[16'h1234]  = 8'hA5;
    sh[0][16'h1234] = 8'hA5;
    sh[1][16'h1234] = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_pause[k] = 0; m_rv[k] = 0;
      m_pre[k] = 0; m_chold[k] = 0; m_vdat[k] = 0; m_vhold[k] = 0;
      last_rdy[k] = 0;
    end
    clear_counts();

    repeat (3) tick();
    reset    = 1'b1;
    cpu_addr = 16'h1234;

    // CPU read of 0x1234
    clear_counts();
    repeat (12) tick();
    chk("t1_rdy_count_d4", 16'(rdy_cnt[0]), 16'd3);
    chk("t1_rdy_count_d6", 16'(rdy_cnt[1]), 16'd2);
    chk("t1_read_d4", 16'(rdy_din[0]), 16'h00A5);
    chk("t1_read_d6", 16'(rdy_din[1]), 16'h00A5);

    // write 0x55 to 0x8000, then read it back
    cpu_addr     = 16'h8000;
    cpu_data_out = 8'h55;
    cpu_we       = 1'b1;
    clear_counts();
    repeat (12) tick();
    chk("t2_we_count_d4", 16'(we_cnt[0]), 16'd3);
    chk("t2_we_count_d6", 16'(we_cnt[1]), 16'd2);
    cpu_we = 1'b0;
    clear_counts();
    repeat (12) tick();
    chk("t2_readback_d4", 16'(rdy_din[0]), 16'h0055);
    chk("t2_readback_d6", 16'(rdy_din[1]), 16'h0055);
    chk("t2_we_idle_d4", 16'(we_cnt[0]), 16'd0);

    // continuous video requests
    vid_req  = 1'b1;
    vid_addr = 16'h8000;
    clear_counts();
    for (int i = 0; i < 24; i++) begin
      tick();
      vid_addr = vid_addr + 16'd1;
    end
    chk("t3_grants_d4", 16'(gnt_cnt[0]), 16'd12);
    chk("t3_grants_d6", 16'(gnt_cnt[1]), 16'd16);
    chk("t3_rvalids_d6", 16'(rv_cnt[1]), 16'd16);

    // pause with a pending write
    vid_req   = 1'b0;
    cpu_addr  = 16'h4000;
    cpu_pause = 1'b1;
    repeat (7) tick();
    cpu_we       = 1'b1;
    cpu_data_out = 8'hEE;
    clear_counts();
    repeat (24) tick();
    chk("t4_paused_rdy_d4", 16'(rdy_cnt[0]), 16'd0);
    chk("t4_paused_rdy_d6", 16'(rdy_cnt[1]), 16'd0);
    chk("t4_paused_we_d4", 16'(we_cnt[0]), 16'd0);
    chk("t4_paused_we_d6", 16'(we_cnt[1]), 16'd0);
    cpu_we    = 1'b0;
    cpu_pause = 1'b0;
    clear_counts();
    repeat (12) tick();
    chk("t4_resume_rdy_d4", 16'(rdy_cnt[0]), 16'd2);
    chk("t4_resume_rdy_d6", 16'(rdy_cnt[1]), 16'd2);
    chk("t4_mem_kept_d4", 16'(rdy_din[0]), 16'h0040);
    chk("t4_mem_kept_d6", 16'(rdy_din[1]), 16'h0040);

    // reset at slot 1 with a video return in flight
    vid_req  = 1'b1;
    vid_addr = 16'h1234;
    found    = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = last_rdy[0];
    end
    chk("t5_wait_rdy_d4", 16'(found), 16'd1);
    tick();
    chk("t5_rvalid_pending_d4", 16'(rv4), 16'd1);
    reset = 1'b0;
    #1;
    compare_cycle();
    chk("t5_rvalid_dropped_d4", 16'(rv4), 16'd0);
    chk("t5_grant_dropped_d4", 16'(gnt4), 16'd0);
    repeat (2) tick();
    reset    = 1'b1;
    vid_req  = 1'b0;
    first[0] = -1;
    first[1] = -1;
    for (n = 0; n < 20; n++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (last_rdy[k] && first[k] < 0) first[k] = n;
    end
    chk("t5_first_rdy_d4", 16'(first[0]), 16'd3);
    chk("t5_first_rdy_d6", 16'(first[1]), 16'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
